// File: rtl/event_pkg.sv
// Event record shared between the stream arbiter and the event-frame preprocessor.
package event_pkg;

    localparam int COORD_W = 14;
    localparam int TS_W    = 34;

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               pol;
    } event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr and wraps.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/event_stream_arbiter.sv
// Round-robin merge of several event streams into the preprocessor's single
// registered event port, dropping events the preprocessor would discard.
module event_stream_arbiter #(
    parameter int NUM_SOURCES  = 4,
    parameter int COORD_W      = event_pkg::COORD_W,
    parameter int TS_W         = event_pkg::TS_W,
    parameter int SENSOR_WIDTH = 64,
    parameter bit POS_ONLY     = 1'b1,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             enable_i,
    input  logic [NUM_SOURCES-1:0]           src_valid_i,
    output logic [NUM_SOURCES-1:0]           src_ready_o,
    input  logic [NUM_SOURCES*TS_W-1:0]      src_ts_i,
    input  logic [NUM_SOURCES*COORD_W-1:0]   src_x_i,
    input  logic [NUM_SOURCES*COORD_W-1:0]   src_y_i,
    input  logic [NUM_SOURCES-1:0]           src_pol_i,
    input  logic                             frame_done_i,
    output logic                             ev_valid_o,
    output logic [TS_W-1:0]                  ev_ts_o,
    output logic [COORD_W-1:0]               ev_x_o,
    output logic [COORD_W-1:0]               ev_y_o,
    output logic                             ev_pol_o,
    output logic [$clog2(NUM_SOURCES)-1:0]   ev_src_o,
    output logic [DROP_CNT_W-1:0]            drop_cnt_o
);

    localparam int                 SRC_W      = $clog2(NUM_SOURCES);
    localparam logic [COORD_W:0]   SENSOR_LIM = (COORD_W+1)'(SENSOR_WIDTH);
    localparam logic [SRC_W-1:0]   LAST_SRC   = SRC_W'(NUM_SOURCES - 1);

    logic [SRC_W-1:0]       ptr;
    logic [SRC_W-1:0]       gnt_idx;
    logic [NUM_SOURCES-1:0] req;
    logic [NUM_SOURCES-1:0] gnt;
    logic                   slot_free;
    logic                   accept;
    logic                   drop;
    logic [TS_W-1:0]        sel_ts;
    logic [COORD_W-1:0]     sel_x;
    logic [COORD_W-1:0]     sel_y;
    logic                   sel_pol;

    // The preprocessor ignores its input on a frame-emit cycle, so a held
    // event must stay put and no new grant may overwrite it.
    assign slot_free = !ev_valid_o || !frame_done_i;
    assign req       = (reset_ni && enable_i && slot_free) ? src_valid_i : '0;

    rr_arbiter #(.N(NUM_SOURCES)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign src_ready_o = gnt;
    assign accept      = |gnt;

    assign sel_ts  = src_ts_i[int'(gnt_idx)*TS_W +: TS_W];
    assign sel_x   = src_x_i[int'(gnt_idx)*COORD_W +: COORD_W];
    assign sel_y   = src_y_i[int'(gnt_idx)*COORD_W +: COORD_W];
    assign sel_pol = src_pol_i[gnt_idx];

    assign drop = ({1'b0, sel_x} >= SENSOR_LIM) || ({1'b0, sel_y} >= SENSOR_LIM) ||
                  (POS_ONLY && !sel_pol);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            ptr        <= '0;
            ev_valid_o <= 1'b0;
            ev_ts_o    <= '0;
            ev_x_o     <= '0;
            ev_y_o     <= '0;
            ev_pol_o   <= 1'b0;
            ev_src_o   <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (accept) begin
                ptr <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
            end
            if (accept && !drop) begin
                ev_valid_o <= 1'b1;
                ev_ts_o    <= sel_ts;
                ev_x_o     <= sel_x;
                ev_y_o     <= sel_y;
                ev_pol_o   <= sel_pol;
                ev_src_o   <= gnt_idx;
            end else if (ev_valid_o && !frame_done_i) begin
                ev_valid_o <= 1'b0;
            end
            if (accept && drop && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_stream_arbiter.sv
// Randomized and directed checks of event_stream_arbiter against a queue-free
// behavioural model of round-robin grant, filtering and frame-emit stalls.
module tb_event_stream_arbiter;
    import event_pkg::*;

    localparam int N  = 4;
    localparam int CW = 14;
    localparam int TW = 34;
    localparam int SW = 64;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic            frame_done;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*TW-1:0] src_ts;
    logic [N*CW-1:0] src_x;
    logic [N*CW-1:0] src_y;
    logic [N-1:0]    src_pol;
    logic            ev_valid;
    logic [TW-1:0]   ev_ts;
    logic [CW-1:0]   ev_x;
    logic [CW-1:0]   ev_y;
    logic            ev_pol;
    logic [1:0]      ev_src;
    logic [DW-1:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    event_stream_arbiter #(
        .NUM_SOURCES(N), .COORD_W(CW), .TS_W(TW),
        .SENSOR_WIDTH(SW), .POS_ONLY(1'b1), .DROP_CNT_W(DW)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n), .enable_i(enable),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_ts_i(src_ts), .src_x_i(src_x), .src_y_i(src_y), .src_pol_i(src_pol),
        .frame_done_i(frame_done),
        .ev_valid_o(ev_valid), .ev_ts_o(ev_ts), .ev_x_o(ev_x), .ev_y_o(ev_y),
        .ev_pol_o(ev_pol), .ev_src_o(ev_src), .drop_cnt_o(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit     m_seen = 1'b0;
    int     m_ptr;
    bit     m_valid;
    event_t m_ev;
    int     m_src;
    int     m_cnt;

    function automatic int first_valid(input int p, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] exp_rdy;
        event_t       e;
        if (m_seen) begin
            chk("ev_valid", ev_valid, m_valid);
            if (m_valid) begin
                chk("ev_ts", ev_ts, m_ev.ts);
                chk("ev_x", ev_x, m_ev.x);
                chk("ev_y", ev_y, m_ev.y);
                chk("ev_pol", ev_pol, m_ev.pol);
                chk("ev_src", ev_src, m_src);
            end
            chk("drop_cnt", drop_cnt, m_cnt);
        end
        g = -1;
        if (reset_n && enable && !(m_valid && frame_done))
            g = first_valid(m_ptr, src_valid);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (m_seen) chk("src_ready", src_ready, exp_rdy);
        if (!reset_n) begin
            m_seen  = 1'b1;
            m_ptr   = 0;
            m_valid = 1'b0;
            m_ev    = '0;
            m_src   = 0;
            m_cnt   = 0;
        end else if (m_seen) begin
            if (m_valid && !frame_done) m_valid = 1'b0;
            if (g >= 0) begin
                e.ts  = src_ts[g*TW +: TW];
                e.x   = src_x[g*CW +: CW];
                e.y   = src_y[g*CW +: CW];
                e.pol = src_pol[g];
                m_ptr = (g + 1) % N;
                if (e.x >= SW || e.y >= SW || !e.pol) begin
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_valid = 1'b1;
                    m_ev    = e;
                    m_src   = g;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_src(input int k, input bit v, input logic [TW-1:0] t,
                           input int xx, input int yy, input bit p);
        src_valid[k]        = v;
        src_ts[k*TW +: TW]  = t;
        src_x[k*CW +: CW]   = CW'(xx);
        src_y[k*CW +: CW]   = CW'(yy);
        src_pol[k]          = p;
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        frame_done = 1'b0;
        src_valid  = '0;
        src_ts     = '0;
        src_x      = '0;
        src_y      = '0;
        src_pol    = '0;
        for (int k = 0; k < N; k++) set_src(k, 1'b1, TW'(100 + k), k, k, 1'b1);

        // reset state, with sources requesting
        step();
        settle();
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_ev_ts", ev_ts, 0);
        chk("rst_ev_src", ev_src, 0);
        chk("rst_ready", src_ready, 0);
        step();

        // all four valid: grants rotate 0,1,2,3,0
        reset_n = 1'b1;
        settle();
        chk("rr_ready0", src_ready, 4'b0001);
        step(); settle();
        chk("rr_ready1", src_ready, 4'b0010);
        chk("rr_src0", ev_src, 0);
        chk("rr_valid", ev_valid, 1);
        step(); settle();
        chk("rr_ready2", src_ready, 4'b0100);
        chk("rr_src1", ev_src, 1);
        step(); settle();
        chk("rr_ready3", src_ready, 4'b1000);
        chk("rr_src2", ev_src, 2);
        step(); settle();
        chk("rr_ready4", src_ready, 4'b0001);
        chk("rr_src3", ev_src, 3);
        step();

        // source 2 alone
        for (int k = 0; k < N; k++) src_valid[k] = 1'b0;
        set_src(2, 1'b1, 34'h123, 10, 20, 1'b1);
        settle();
        chk("solo_ready", src_ready, 4'b0100);
        step();
        src_valid[2] = 1'b0;
        set_src(0, 1'b1, 34'h55, 3, 4, 1'b1);
        set_src(1, 1'b1, 34'h66, 5, 6, 1'b1);
        frame_done = 1'b1;
        settle();
        chk("solo_x", ev_x, 10);
        chk("solo_y", ev_y, 20);
        chk("solo_ts", ev_ts, 34'h123);
        chk("solo_src", ev_src, 2);
        chk("fd_ready", src_ready, 4'b0000);
        step();
        frame_done = 1'b0;
        settle();
        chk("fd_hold_valid", ev_valid, 1);
        chk("fd_hold_x", ev_x, 10);
        chk("fd_hold_src", ev_src, 2);
        chk("fd_next_ready", src_ready, 4'b0001);
        step();

        // source 1: out-of-range x, negative polarity, then a good event
        src_valid[0] = 1'b0;
        set_src(1, 1'b1, 34'h77, 64, 1, 1'b1);
        settle();
        chk("drop_ready", src_ready, 4'b0010);
        chk("drop_prev_src", ev_src, 0);
        step();
        set_src(1, 1'b1, 34'h78, 5, 5, 1'b0);
        settle();
        chk("drop1_cnt", drop_cnt, 1);
        chk("drop1_valid", ev_valid, 0);
        step();
        set_src(1, 1'b1, 34'h79, 7, 8, 1'b1);
        settle();
        chk("drop2_cnt", drop_cnt, 2);
        chk("drop2_valid", ev_valid, 0);
        step();
        src_valid[1] = 1'b0;
        set_src(2, 1'b1, 34'h80, 1, 2, 1'b1);
        settle();
        chk("keep_valid", ev_valid, 1);
        chk("keep_x", ev_x, 7);
        chk("keep_cnt", drop_cnt, 2);
        step();

        // mid-stream reset with ptr at 3 and an event held
        reset_n = 1'b0;
        for (int k = 0; k < N; k++) set_src(k, 1'b1, TW'(200 + k), k, k, 1'b1);
        settle();
        chk("mid_held_valid", ev_valid, 1);
        chk("mid_held_src", ev_src, 2);
        chk("mid_rst_ready", src_ready, 0);
        step();
        reset_n = 1'b1;
        settle();
        chk("mid_ev_valid", ev_valid, 0);
        chk("mid_drop_cnt", drop_cnt, 0);
        chk("mid_ready", src_ready, 4'b0001);
        step();

        // randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++)
                set_src(k, $urandom_range(0, 2) != 0, {2'($urandom), 32'($urandom)},
                        $urandom_range(0, 79), $urandom_range(0, 79), 1'($urandom_range(0, 1)));
            frame_done = ($urandom_range(0, 4) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            reset_n    = ($urandom_range(0, 499) != 0);
            step();
        end

        // drop-counter saturation
        reset_n    = 1'b0;
        enable     = 1'b1;
        frame_done = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) set_src(k, 1'b1, TW'(k), 100, 1, 1'b1);
        repeat (65535) step();
        settle();
        chk("sat_reach", drop_cnt, 16'hFFFF);
        step();
        settle();
        chk("sat_hold", drop_cnt, 16'hFFFF);
        chk("sat_valid", ev_valid, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
